// File: rtl/booth_mult_seq.sv
// booth_mult_seq: sequential radix-2 Booth multiplier with valid/ready handshakes and signed/unsigned mode
module booth_mult_seq #(
   parameter int N     = 8,
   parameter int CNT_W = $clog2(N+2)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N-1:0]   A,
   input  logic [N-1:0]   B,
   input  logic           is_signed,
   output logic           out_valid,
   input  logic           out_ready,
   output logic           busy,
   output logic [2*N-1:0] Y
);
   localparam int W = N + 1;
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t state, state_nx;
   logic [W-1:0] hq, lq, m, sum;
   logic q1;
   logic [CNT_W-1:0] cnt;
   logic [2*W:0] acc_nx;
   logic accept, last_step;
   assign in_ready  = state == IDLE;
   assign busy      = state != IDLE;
   assign out_valid = state == DONE;
   assign accept    = in_valid & in_ready;
   assign last_step = state == CALC && cnt == CNT_W'(1);
   // one Booth step: add/subtract M by {LQ[0],Q_1}, then arithmetic shift of {HQ,LQ,Q_1}
   always_comb begin
      sum    = ({lq[0], q1} == 2'b01) ? hq + m : ({lq[0], q1} == 2'b10) ? hq - m : hq;
      acc_nx = {sum[W-1], sum, lq};
   end
   // state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end
   // next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = accept ? CALC : IDLE;
         CALC:    state_nx = last_step ? DONE : CALC;
         DONE:    state_nx = out_ready ? IDLE : DONE;
         default: state_nx = IDLE;
      endcase
   end
   // datapath: load extended operands on accept, step while calculating, capture product on the last step
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hq  <= '0;
         lq  <= '0;
         q1  <= 1'b0;
         m   <= '0;
         cnt <= '0;
         Y   <= '0;
      end else if (accept) begin
         m   <= {is_signed & A[N-1], A};
         hq  <= '0;
         lq  <= {is_signed & B[N-1], B};
         q1  <= 1'b0;
         cnt <= CNT_W'(W);
      end else if (state == CALC) begin
         hq  <= acc_nx[2*W:W+1];
         lq  <= acc_nx[W:1];
         q1  <= acc_nx[0];
         cnt <= cnt - CNT_W'(1);
         if (last_step) Y <= acc_nx[2*N:1];
      end
   end
endmodule

// File: tb/tb_booth_mult_seq.sv
// tb_booth_mult_seq: directed and randomized checks of booth_mult_seq against an arithmetic product model
module tb_booth_mult_seq;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  A = '0;
   logic [7:0]  B = '0;
   logic        is_signed = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        busy;
   logic [15:0] Y;
   int tests = 0;
   int fails = 0;

   booth_mult_seq #(.N(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .is_signed(is_signed), .out_valid(out_valid),
      .out_ready(out_ready), .busy(busy), .Y(Y)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b, input logic s);
      longint x, y;
      x = s ? longint'($signed(a)) : longint'(a);
      y = s ? longint'($signed(b)) : longint'(b);
      return 16'(x * y);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_txn(input logic [7:0] a, input logic [7:0] b, input logic s);
      int n = 0;
      while (!in_ready && n < 30) begin tick(); n++; end
      chk("accept_wait", 32'(n < 30), 32'd1);
      A = a; B = b; is_signed = s; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("busy_after_accept", 32'(busy), 32'd1);
      chk("in_ready_after_accept", 32'(in_ready), 32'd0);
   endtask

   task automatic finish_txn(input logic [15:0] exp, input int hold);
      int n = 0;
      while (!out_valid && n < 30) begin tick(); n++; end
      chk("latency", 32'(n), 32'd9);
      chk("product", 32'(Y), 32'(exp));
      for (int i = 0; i < hold; i++) begin
         tick();
         chk("hold_out_valid", 32'(out_valid), 32'd1);
         chk("hold_y", 32'(Y), 32'(exp));
         chk("hold_in_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("out_valid_dropped", 32'(out_valid), 32'd0);
      chk("in_ready_back", 32'(in_ready), 32'd1);
      chk("busy_cleared", 32'(busy), 32'd0);
   endtask

   initial begin
      logic [7:0] ra, rb;
      logic rs;
      #1;
      chk("reset_in_ready", 32'(in_ready), 32'd1);
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_y", 32'(Y), 32'd0);
      #12 rst = 1'b1;
      tick();
      out_ready = 1'b1;
      tick();
      chk("out_ready_ignored_idle", 32'(out_valid), 32'd0);
      out_ready = 1'b0;
      start_txn(8'd7, 8'hFD, 1'b1);     finish_txn(16'hFFEB, 0);
      start_txn(8'hFF, 8'hFF, 1'b0);    finish_txn(16'hFE01, 0);
      start_txn(8'hFF, 8'hFF, 1'b1);    finish_txn(16'h0001, 0);
      start_txn(8'h80, 8'h80, 1'b1);    finish_txn(16'h4000, 0);
      start_txn(8'h80, 8'h7F, 1'b1);    finish_txn(16'hC080, 0);
      start_txn(8'h80, 8'h80, 1'b0);    finish_txn(16'h4000, 0);
      start_txn(8'd13, 8'd11, 1'b0);    finish_txn(16'd143, 20);
      start_txn(8'h00, 8'h5A, 1'b1);    finish_txn(16'h0000, 0);
      start_txn(8'd3, 8'd5, 1'b0);
      A = 8'h11; B = 8'h22; is_signed = 1'b0; in_valid = 1'b1;
      finish_txn(16'd15, 0);
      start_txn(8'h11, 8'h22, 1'b0);    finish_txn(16'h0242, 0);
      for (int i = 0; i < 24; i++) begin
         ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
         start_txn(ra, rb, rs);
         finish_txn(model(ra, rb, rs), int'($urandom_range(0, 3)));
      end
      start_txn(8'hC3, 8'h9E, 1'b1);
      tick(); tick(); tick();
      #2 rst = 1'b0;
      #1;
      chk("midcalc_rst_out_valid", 32'(out_valid), 32'd0);
      chk("midcalc_rst_in_ready", 32'(in_ready), 32'd1);
      chk("midcalc_rst_busy", 32'(busy), 32'd0);
      chk("midcalc_rst_y", 32'(Y), 32'd0);
      #13 rst = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         chk("no_stale_out_valid", 32'(out_valid), 32'd0);
      end
      start_txn(8'hFF, 8'hFF, 1'b1);    finish_txn(16'h0001, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
